// File: rtl/pid_led_mc.sv
// pid_led_mc: one shared PID datapath that services CH UV LED current channels.
// Each channel takes four cycles (ERR, MUL, SUM, WB), then a one-cycle DONE pulse follows.
module pid_led_mc #(
    parameter int CH      = 4,
    parameter int DW      = 32,
    parameter int FRAC    = 23,
    parameter int OUT_MAX = 167772,
    parameter int INT_MAX = 2**30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CH*DW-1:0] p_target,
    input  logic [CH*DW-1:0] p_measure,
    input  logic [DW-1:0]    kp,
    input  logic [DW-1:0]    ki,
    input  logic [DW-1:0]    kd,
    input  logic [CH-1:0]    ch_en,
    output logic [CH*DW-1:0] i_current,
    output logic             busy,
    output logic             done
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = 2*DW + 2;
    localparam int NW = PW + 2;
    localparam logic signed [DW+1:0] IMAX  = (DW+2)'(INT_MAX);
    localparam logic signed [DW+1:0] IMIN  = -IMAX;
    localparam logic signed [NW-1:0] OMAX  = NW'(OUT_MAX);
    localparam logic [DW-1:0]        OUT_W = DW'(OUT_MAX);

    typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, WB, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          ch;
    logic [DW-1:0]          tgt_s [CH];
    logic [DW-1:0]          meas_s[CH];
    logic [DW-1:0]          cur   [CH];
    logic signed [DW:0]     integ [CH];
    logic signed [DW:0]     prev_e[CH];
    logic [DW-1:0]          kp_s, ki_s, kd_s;
    logic [CH-1:0]          en_s;
    logic signed [DW:0]     e_r, integ_r;
    logic signed [DW+1:0]   d_r;
    logic signed [PW-1:0]   p_r, i_r, dd_r;
    logic [DW-1:0]          n_r;

    logic [DW-1:0]          cur_c;
    logic signed [DW:0]     e_c, integ_c;
    logic signed [DW+1:0]   d_c, isum;
    logic                   hold;
    logic signed [NW-1:0]   n_c;

    function automatic logic signed [NW-1:0] shr(input logic signed [PW-1:0] x);
        return $signed({{2{x[PW-1]}}, x}) >>> FRAC;
    endfunction

    assign cur_c = cur[ch];

    always_comb begin
        e_c  = $signed({1'b0, tgt_s[ch]}) - $signed({1'b0, meas_s[ch]});
        d_c  = $signed({e_c[DW], e_c}) - $signed({prev_e[ch][DW], prev_e[ch]});
        isum = $signed({integ[ch][DW], integ[ch]}) + $signed({e_c[DW], e_c});
        // Freeze the integral while the output is pinned and the error pushes further out.
        hold = (cur_c == OUT_W && !e_c[DW] && e_c != '0) ||
               (cur_c == '0 && e_c[DW]);
        integ_c = integ[ch];
        if (!hold) begin
            if (isum > IMAX)      integ_c = IMAX[DW:0];
            else if (isum < IMIN) integ_c = IMIN[DW:0];
            else                  integ_c = isum[DW:0];
        end
        n_c = $signed({{(NW-DW){1'b0}}, cur_c}) + shr(p_r) + shr(i_r) + shr(dd_r);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            kp_s    <= '0;
            ki_s    <= '0;
            kd_s    <= '0;
            en_s    <= '0;
            e_r     <= '0;
            integ_r <= '0;
            d_r     <= '0;
            p_r     <= '0;
            i_r     <= '0;
            dd_r    <= '0;
            n_r     <= '0;
            for (int c = 0; c < CH; c++) begin
                tgt_s[c]  <= '0;
                meas_s[c] <= '0;
                cur[c]    <= '0;
                integ[c]  <= '0;
                prev_e[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    for (int c = 0; c < CH; c++) begin
                        tgt_s[c]  <= p_target[c*DW +: DW];
                        meas_s[c] <= p_measure[c*DW +: DW];
                    end
                    kp_s  <= kp;
                    ki_s  <= ki;
                    kd_s  <= kd;
                    en_s  <= ch_en;
                    ch    <= '0;
                    busy  <= 1'b1;
                    state <= ERR;
                end
                ERR: begin
                    e_r     <= e_c;
                    d_r     <= d_c;
                    integ_r <= integ_c;
                    state   <= MUL;
                end
                MUL: begin
                    p_r  <= $signed({{(PW-DW){1'b0}}, kp_s}) *
                            $signed({{(PW-DW-1){e_r[DW]}}, e_r});
                    i_r  <= $signed({{(PW-DW){1'b0}}, ki_s}) *
                            $signed({{(PW-DW-1){integ_r[DW]}}, integ_r});
                    dd_r <= $signed({{(PW-DW){1'b0}}, kd_s}) *
                            $signed({{(PW-DW-2){d_r[DW+1]}}, d_r});
                    state <= SUM;
                end
                SUM: begin
                    n_r   <= n_c[NW-1] ? '0 : (n_c > OMAX) ? OUT_W : n_c[DW-1:0];
                    state <= WB;
                end
                WB: begin
                    cur[ch]    <= en_s[ch] ? n_r : '0;
                    integ[ch]  <= en_s[ch] ? integ_r : '0;
                    prev_e[ch] <= en_s[ch] ? e_r : '0;
                    if (ch == CW'(CH-1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ch    <= ch + CW'(1);
                        state <= ERR;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_out
        assign i_current[c*DW +: DW] = cur[c];
    end
endmodule

// File: tb/tb_pid_led_mc.sv
// Bench for pid_led_mc: a behavioural PID model fills a scoreboard at each start,
// and each done pulse pops and checks it, together with sweep timing and reset.
module tb_pid_led_mc;
    localparam int CH      = 4;
    localparam int DW      = 32;
    localparam int FRAC    = 23;
    localparam int OUT_MAX = 167772;
    localparam int INT_MAX = 2**30;
    localparam int SWEEP   = 4*CH + 1;

    typedef logic [CH*DW-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CH*DW-1:0] p_target = '0;
    logic [CH*DW-1:0] p_measure = '0;
    logic [DW-1:0]    kp = '0, ki = '0, kd = '0;
    logic [CH-1:0]    ch_en = '0;
    logic [CH*DW-1:0] i_current;
    logic             busy, done;

    pid_led_mc #(.CH(CH), .DW(DW), .FRAC(FRAC), .OUT_MAX(OUT_MAX), .INT_MAX(INT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p_target(p_target), .p_measure(p_measure),
        .kp(kp), .ki(ki), .kd(kd), .ch_en(ch_en),
        .i_current(i_current), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    vec_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    longint m_cur[CH], m_int[CH], m_prev[CH];
    longint tgt[CH], meas[CH];
    longint g_kp, g_ki, g_kd;
    logic [CH-1:0] en;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int c = 0; c < CH; c++) begin
            p_target[c*DW +: DW]  = tgt[c][DW-1:0];
            p_measure[c*DW +: DW] = meas[c][DW-1:0];
        end
        kp = g_kp[DW-1:0];
        ki = g_ki[DW-1:0];
        kd = g_kd[DW-1:0];
        ch_en = en;
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_cur[c] = 0;
            m_int[c] = 0;
            m_prev[c] = 0;
        end
    endtask

    task automatic model_sweep();
        vec_t v;
        longint e, d, ni;
        logic signed [127:0] pe, pi, pd, n;
        bit hold;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            e = tgt[c] - meas[c];
            d = e - m_prev[c];
            hold = (m_cur[c] == OUT_MAX && e > 0) || (m_cur[c] == 0 && e < 0);
            ni = hold ? m_int[c] : m_int[c] + e;
            if (ni > INT_MAX) ni = INT_MAX;
            if (ni < -INT_MAX) ni = -INT_MAX;
            pe = g_kp; pe = pe * e;
            pi = g_ki; pi = pi * ni;
            pd = g_kd; pd = pd * d;
            n = m_cur[c];
            n = n + (pe >>> FRAC) + (pi >>> FRAC) + (pd >>> FRAC);
            if (n < 0) n = 0;
            else if (n > OUT_MAX) n = OUT_MAX;
            if (en[c]) begin
                m_cur[c] = longint'(n);
                m_int[c] = ni;
                m_prev[c] = e;
            end else begin
                m_cur[c] = 0;
                m_int[c] = 0;
                m_prev[c] = 0;
            end
            v[c*DW +: DW] = m_cur[c][DW-1:0];
        end
        sb.push_back(v);
    endtask

    task automatic sweep(input bit glitch);
        vec_t old_v, new_v, got, exp_v;
        longint want;
        int done_at, done_n, busy_n, bad_t;
        done_at = -1; done_n = 0; busy_n = 0; bad_t = 0;
        for (int c = 0; c < CH; c++) old_v[c*DW +: DW] = m_cur[c][DW-1:0];
        apply_inputs();
        model_sweep();
        new_v = sb[$];
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= SWEEP + 3; k++) begin
            got = i_current;
            if (busy) busy_n++;
            if (busy !== (k <= SWEEP)) bad_t++;
            for (int c = 0; c < CH; c++) begin
                want = (k >= 4*c + 5) ? longint'(new_v[c*DW +: DW]) : longint'(old_v[c*DW +: DW]);
                if (longint'(got[c*DW +: DW]) != want) bad_t++;
            end
            if (done) begin
                done_n++;
                done_at = k;
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    exp_v = sb.pop_front();
                    for (int c = 0; c < CH; c++)
                        check($sformatf("i_current[%0d]", c),
                              longint'(got[c*DW +: DW]), longint'(exp_v[c*DW +: DW]));
                end
            end
            start = glitch && (k == 5 || k == SWEEP);
            if (glitch && k == 5) begin
                p_target = {CH*DW{1'b1}};
                kp = '1;
                ch_en = '0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        apply_inputs();
        check("done_cycle", done_at, SWEEP);
        check("done_count", done_n, 1);
        check("busy_count", busy_n, SWEEP);
        check("sweep_timing", bad_t, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        for (int c = 0; c < CH; c++)
            check($sformatf("rst_i_current[%0d]", c), longint'(i_current[c*DW +: DW]), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_mid();
        apply_inputs();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_ch0_written", longint'(i_current[DW-1:0] != '0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check("mid_rst_out", longint'(i_current != '0), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            tgt[c] = 0;
            meas[c] = 0;
        end
        g_kp = 0; g_ki = 0; g_kd = 0; en = '1;
        model_clear();
        apply_inputs();
        repeat (2) @(negedge clk);
        do_reset();

        // proportional only
        g_kp = 64'd1 << 23;
        tgt[0] = 100;
        sweep(0);
        check("p_only_s1", longint'(i_current[DW-1:0]), 100);
        sweep(0);
        check("p_only_s2", longint'(i_current[DW-1:0]), 200);
        check("p_only_others", longint'(i_current[CH*DW-1:DW] != '0), 0);

        // upper and lower saturation
        tgt[0] = 1000000;
        sweep(0);
        sweep(0);
        check("sat_high", longint'(i_current[DW-1:0]), OUT_MAX);
        tgt[0] = 0; meas[0] = 500000;
        sweep(0);
        check("sat_low", longint'(i_current[DW-1:0]), 0);

        // anti-windup
        do_reset();
        meas[0] = 0; tgt[0] = 1000;
        g_kp = 64'd200 << 23; g_ki = 64'd1 << 23; g_kd = 0;
        repeat (3) sweep(0);
        check("aw_sat", longint'(i_current[DW-1:0]), OUT_MAX);
        tgt[0] = 0; meas[0] = 10;
        sweep(0);
        check("aw_release", longint'(i_current[DW-1:0]), 166762);

        // channel enables
        g_kp = 64'd1 << 23; g_ki = 64'd1 << 22; g_kd = 64'd1 << 21;
        tgt[0] = 5000; tgt[1] = 3000; tgt[2] = 7000; tgt[3] = 2000;
        meas[0] = 1000; meas[1] = 3500; meas[2] = 100; meas[3] = 0;
        sweep(0);
        en = 4'b1011;
        sweep(0);
        check("ch2_disabled", longint'(i_current[2*DW +: DW]), 0);
        en = 4'b1111;
        sweep(0);

        // start while busy and inputs changing after capture
        tgt[1] = 9000;
        sweep(1);

        // reset in mid-sweep, then a normal sweep
        reset_mid();
        sweep(0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
